// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI3 read-path arbiter.
// Holds the FSM state and grant encodings, the AXI response codes and the
// default widths used by axi_rd_arb2 and rr_arb2.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } grant_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ID_MAX_DEF   = 3;
    localparam int DATA_MAX_DEF = 63;
    localparam int ADDR_W       = 32;
    localparam int LEN_W        = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin pick.
// Ports:
//   req_i        - request vector, bit n from master n
//   last_grant_i - index of the master granted most recently
//   gnt_valid_o  - at least one request present
//   gnt_idx_o    - chosen master; on a tie the one that was not last granted
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ~last_grant_i;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_rd_arb2.sv
// Two-master to one-slave AXI3 read-path arbiter (AR and R channels).
// Serialises bursts round-robin, holds the grant until the final beat of the
// granted burst is accepted, and returns the stored ARID on RID.
// Ports:
//   ACLK, ARESETn             - clock, asynchronous active-low reset
//   M0_*/M1_* AR channel      - master address requests (ARREADY out)
//   M0_*/M1_* R channel       - read beats toward each master (RREADY in)
//   S_* AR/R channels         - single slave port
//   LEN_ERR                   - sticky burst-length mismatch flag
// Build option: define AXI_RD_ARB_LEN_CHECK_EN to terminate bursts on the
// ARLEN beat count and flag/SLVERR any disagreement with S_RLAST. Without it
// S_RLAST alone ends the burst and LEN_ERR is tied low.
module axi_rd_arb2
    import axi_rd_arb_pkg::*;
#(
    parameter int ID_MAX   = ID_MAX_DEF,
    parameter int DATA_MAX = DATA_MAX_DEF
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // master 0
    input  logic [ID_MAX:0]     M0_ARID,
    input  logic [31:0]         M0_ARADDR,
    input  logic [3:0]          M0_ARLEN,
    input  logic [2:0]          M0_ARSIZE,
    input  logic [1:0]          M0_ARBURST,
    input  logic                M0_ARVALID,
    output logic                M0_ARREADY,
    output logic [ID_MAX:0]     M0_RID,
    output logic [DATA_MAX:0]   M0_RDATA,
    output logic [1:0]          M0_RRESP,
    output logic                M0_RLAST,
    output logic                M0_RVALID,
    input  logic                M0_RREADY,
    // master 1
    input  logic [ID_MAX:0]     M1_ARID,
    input  logic [31:0]         M1_ARADDR,
    input  logic [3:0]          M1_ARLEN,
    input  logic [2:0]          M1_ARSIZE,
    input  logic [1:0]          M1_ARBURST,
    input  logic                M1_ARVALID,
    output logic                M1_ARREADY,
    output logic [ID_MAX:0]     M1_RID,
    output logic [DATA_MAX:0]   M1_RDATA,
    output logic [1:0]          M1_RRESP,
    output logic                M1_RLAST,
    output logic                M1_RVALID,
    input  logic                M1_RREADY,
    // slave
    output logic [ID_MAX:0]     S_ARID,
    output logic [31:0]         S_ARADDR,
    output logic [3:0]          S_ARLEN,
    output logic [2:0]          S_ARSIZE,
    output logic [1:0]          S_ARBURST,
    output logic                S_ARVALID,
    input  logic                S_ARREADY,
    input  logic [ID_MAX:0]     S_RID,
    input  logic [DATA_MAX:0]   S_RDATA,
    input  logic [1:0]          S_RRESP,
    input  logic                S_RLAST,
    input  logic                S_RVALID,
    output logic                S_RREADY,
    output logic                LEN_ERR
);

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d;
    grant_e          last_grant_q, last_grant_d;
    logic [ID_MAX:0] id_q, id_d;

    logic gnt_valid;
    logic gnt_idx;
    logic sel_m1;
    logic rready_sel;
    logic beat_fire;
    logic final_beat;
    logic r_last;
    logic [1:0] r_resp;

    // The slave always returns a fixed RID; the stored ARID replaces it.
    logic unused_rid;
    assign unused_rid = ^S_RID;

    rr_arb2 u_rr_arb2 (
        .req_i        ({M1_ARVALID, M0_ARVALID}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    assign sel_m1     = (grant_q == M1);
    assign rready_sel = sel_m1 ? M1_RREADY : M0_RREADY;
    assign beat_fire  = (state_q == DATA) && S_RVALID && rready_sel;

`ifdef AXI_RD_ARB_LEN_CHECK_EN
    logic [3:0] cnt_q, cnt_d;
    logic       len_err_q, len_err_d;
    logic       cnt_zero;
    logic       len_mis;

    // Either the counter or S_RLAST ends the burst; disagreement is an error
    // that is reported on the terminating beat.
    assign cnt_zero   = (cnt_q == '0);
    assign len_mis    = (S_RLAST != cnt_zero);
    assign final_beat = cnt_zero | S_RLAST;
    assign r_last     = final_beat;
    assign r_resp     = len_mis ? RESP_SLVERR : S_RRESP;
    assign LEN_ERR    = len_err_q;
`else
    assign final_beat = S_RLAST;
    assign r_last     = S_RLAST;
    assign r_resp     = S_RRESP;
    assign LEN_ERR    = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            grant_q      <= M0;
            last_grant_q <= M1;
            id_q         <= '0;
`ifdef AXI_RD_ARB_LEN_CHECK_EN
            cnt_q        <= '0;
            len_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
`ifdef AXI_RD_ARB_LEN_CHECK_EN
            cnt_q        <= cnt_d;
            len_err_q    <= len_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
`ifdef AXI_RD_ARB_LEN_CHECK_EN
        cnt_d        = cnt_q;
        len_err_d    = len_err_q;
`endif
        S_ARVALID  = 1'b0;
        S_ARID     = '0;
        S_ARADDR   = '0;
        S_ARLEN    = '0;
        S_ARSIZE   = '0;
        S_ARBURST  = '0;
        S_RREADY   = 1'b0;
        M0_ARREADY = 1'b0;
        M1_ARREADY = 1'b0;
        M0_RID     = '0;
        M0_RDATA   = '0;
        M0_RRESP   = '0;
        M0_RLAST   = 1'b0;
        M0_RVALID  = 1'b0;
        M1_RID     = '0;
        M1_RDATA   = '0;
        M1_RRESP   = '0;
        M1_RLAST   = 1'b0;
        M1_RVALID  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt_idx ? M1 : M0;
                    id_d    = gnt_idx ? M1_ARID : M0_ARID;
`ifdef AXI_RD_ARB_LEN_CHECK_EN
                    cnt_d   = gnt_idx ? M1_ARLEN : M0_ARLEN;
`endif
                    state_d = ADDR;
                end
            end
            ADDR: begin
                S_ARVALID  = 1'b1;
                S_ARID     = sel_m1 ? M1_ARID    : M0_ARID;
                S_ARADDR   = sel_m1 ? M1_ARADDR  : M0_ARADDR;
                S_ARLEN    = sel_m1 ? M1_ARLEN   : M0_ARLEN;
                S_ARSIZE   = sel_m1 ? M1_ARSIZE  : M0_ARSIZE;
                S_ARBURST  = sel_m1 ? M1_ARBURST : M0_ARBURST;
                M0_ARREADY = !sel_m1 && S_ARREADY;
                M1_ARREADY = sel_m1 && S_ARREADY;
                if (S_ARREADY) begin
                    last_grant_d = grant_q;
                    state_d      = DATA;
                end
            end
            DATA: begin
                S_RREADY = rready_sel;
                if (sel_m1) begin
                    M1_RID    = id_q;
                    M1_RDATA  = S_RDATA;
                    M1_RRESP  = r_resp;
                    M1_RLAST  = r_last;
                    M1_RVALID = S_RVALID;
                end else begin
                    M0_RID    = id_q;
                    M0_RDATA  = S_RDATA;
                    M0_RRESP  = r_resp;
                    M0_RLAST  = r_last;
                    M0_RVALID = S_RVALID;
                end
                if (beat_fire) begin
                    if (final_beat) begin
                        state_d = IDLE;
                    end
`ifdef AXI_RD_ARB_LEN_CHECK_EN
                    if (len_mis) begin
                        len_err_d = 1'b1;
                    end
                    // Exit is decided before the decrement, so the counter never wraps.
                    if (!final_beat) begin
                        cnt_d = cnt_q - 4'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Self-checking bench for axi_rd_arb2: a slave memory model answers AR
// requests one at a time; expected beats are queued from the bench's own
// request table when the slave accepts each AR and popped as masters accept.
module tb_axi_rd_arb2;
    import axi_rd_arb_pkg::*;

`ifdef AXI_RD_ARB_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        int          early;
    } ar_t;

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic [3:0]  M0_ARID, M1_ARID;
    logic [31:0] M0_ARADDR, M1_ARADDR;
    logic [3:0]  M0_ARLEN, M1_ARLEN;
    logic [2:0]  M0_ARSIZE, M1_ARSIZE;
    logic [1:0]  M0_ARBURST, M1_ARBURST;
    logic        M0_ARVALID, M1_ARVALID;
    logic        M0_ARREADY, M1_ARREADY;
    logic [3:0]  M0_RID, M1_RID;
    logic [63:0] M0_RDATA, M1_RDATA;
    logic [1:0]  M0_RRESP, M1_RRESP;
    logic        M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID;
    logic        M0_RREADY, M1_RREADY;
    logic [3:0]  S_ARID;
    logic [31:0] S_ARADDR;
    logic [3:0]  S_ARLEN;
    logic [2:0]  S_ARSIZE;
    logic [1:0]  S_ARBURST;
    logic        S_ARVALID, S_ARREADY;
    logic [3:0]  S_RID;
    logic [63:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RLAST, S_RVALID, S_RREADY;
    logic        LEN_ERR;

    int errors = 0;
    int checks = 0;
    int cnt_rv [2] = '{0, 0};
    ar_t   ar_exp [$];
    beat_t beat_q [$];
    ar_t   mon_e;
    beat_t mon_b;

    always #5 ACLK = ~ACLK;

    axi_rd_arb2 #(.ID_MAX(3), .DATA_MAX(63)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN),
        .M0_ARSIZE(M0_ARSIZE), .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID),
        .M0_ARREADY(M0_ARREADY), .M0_RID(M0_RID), .M0_RDATA(M0_RDATA),
        .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID),
        .M0_RREADY(M0_RREADY),
        .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN),
        .M1_ARSIZE(M1_ARSIZE), .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID),
        .M1_ARREADY(M1_ARREADY), .M1_RID(M1_RID), .M1_RDATA(M1_RDATA),
        .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID),
        .M1_RREADY(M1_RREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY), .S_RID(S_RID), .S_RDATA(S_RDATA),
        .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID),
        .S_RREADY(S_RREADY), .LEN_ERR(LEN_ERR)
    );

    // Slave memory content: the beat at address A carries bytes (A-8)..(A-1), LSB first.
    function automatic logic [63:0] beat_data(input logic [31:0] a);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(a - 32'd8 + 32'(j));
        return d;
    endfunction

    // Slave model: one burst at a time, fixed RID, optional early RLAST.
    logic        s_busy;
    logic [31:0] s_addr;
    logic [3:0]  s_len, s_beat;
    int          early_idx = -1;

    assign S_ARREADY = !s_busy;
    assign S_RVALID  = s_busy;
    assign S_RID     = 4'hA;
    assign S_RRESP   = 2'b00;
    assign S_RDATA   = beat_data(s_addr + {25'd0, s_beat, 3'd0});
    assign S_RLAST   = s_busy && ((s_beat == s_len) || (int'(s_beat) == early_idx));

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            s_busy <= 1'b0;
            s_addr <= '0;
            s_len  <= '0;
            s_beat <= '0;
        end else if (!s_busy) begin
            if (S_ARVALID) begin
                s_busy <= 1'b1;
                s_addr <= S_ARADDR;
                s_len  <= S_ARLEN;
                s_beat <= '0;
            end
        end else if (S_RREADY) begin
            if (S_RLAST) s_busy <= 1'b0;
            else         s_beat <= s_beat + 4'd1;
        end
    end

    // Scoreboard: AR order against the bench's table, beats against the queue.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (S_ARVALID && S_ARREADY) begin
                checks++;
                if (ar_exp.size() == 0) begin
                    errors++;
                    $display("FAIL ar_order: unexpected AR id=%h addr=%h, want none", S_ARID, S_ARADDR);
                end else begin
                    mon_e = ar_exp.pop_front();
                    if ((M1_ARREADY ? 1 : 0) != mon_e.m || S_ARID !== mon_e.id || S_ARADDR !== mon_e.addr ||
                        S_ARLEN !== mon_e.len || S_ARSIZE !== 3'd3 || S_ARBURST !== 2'b01) begin
                        errors++;
                        $display("FAIL ar_order: got m=%0d id=%h addr=%h len=%0d size=%0d burst=%0d, want m=%0d id=%h addr=%h len=%0d size=3 burst=1",
                                 M1_ARREADY ? 1 : 0, S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST,
                                 mon_e.m, mon_e.id, mon_e.addr, mon_e.len);
                    end
                    for (int k = 0; k <= ((mon_e.early >= 0) ? mon_e.early : int'(mon_e.len)); k++) begin
                        mon_b.m    = mon_e.m;
                        mon_b.id   = mon_e.id;
                        mon_b.data = beat_data(mon_e.addr + 32'(k * 8));
                        mon_b.last = (k == ((mon_e.early >= 0) ? mon_e.early : int'(mon_e.len)));
                        mon_b.resp = (LEN_CHK && mon_e.early >= 0 && mon_b.last) ? 2'b10 : 2'b00;
                        beat_q.push_back(mon_b);
                    end
                end
            end
            checks++;
            if (M0_RVALID && M1_RVALID) begin
                errors++;
                $display("FAIL both_rvalid: got M0_RVALID=1 M1_RVALID=1, want at most one");
            end
            for (int m = 0; m < 2; m++) begin
                if (m == 0 ? (M0_RVALID && M0_RREADY) : (M1_RVALID && M1_RREADY)) begin
                    cnt_rv[m]++;
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat: unexpected beat on M%0d data=%h, want none", m,
                                 m == 0 ? M0_RDATA : M1_RDATA);
                    end else begin
                        mon_b = beat_q.pop_front();
                        if (mon_b.m != m ||
                            (m == 0 ? M0_RDATA : M1_RDATA) !== mon_b.data ||
                            (m == 0 ? M0_RID   : M1_RID)   !== mon_b.id   ||
                            (m == 0 ? M0_RRESP : M1_RRESP) !== mon_b.resp ||
                            (m == 0 ? M0_RLAST : M1_RLAST) !== mon_b.last) begin
                            errors++;
                            $display("FAIL beat: got m=%0d data=%h id=%h resp=%b last=%b, want m=%0d data=%h id=%h resp=%b last=%b",
                                     m, m == 0 ? M0_RDATA : M1_RDATA, m == 0 ? M0_RID : M1_RID,
                                     m == 0 ? M0_RRESP : M1_RRESP, m == 0 ? M0_RLAST : M1_RLAST,
                                     mon_b.m, mon_b.data, mon_b.id, mon_b.resp, mon_b.last);
                        end
                    end
                end
            end
        end
    end

    task automatic ar_send(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        @(negedge ACLK);
        if (m == 0) begin
            M0_ARID = id; M0_ARADDR = addr; M0_ARLEN = len; M0_ARVALID = 1'b1;
        end else begin
            M1_ARID = id; M1_ARADDR = addr; M1_ARLEN = len; M1_ARVALID = 1'b1;
        end
        while (!(m == 0 ? M0_ARREADY : M1_ARREADY) && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL ar_send M%0d: ARREADY not seen within %0d cycles, want handshake", m, n);
        end else begin
            @(posedge ACLK);
            #1;
        end
        if (m == 0) M0_ARVALID = 1'b0;
        else        M1_ARVALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((beat_q.size() != 0 || ar_exp.size() != 0 || s_busy) && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s drain: %0d beats and %0d ARs outstanding, want 0", name, beat_q.size(), ar_exp.size());
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        @(negedge ACLK);
        beat_q.delete();
        ar_exp.delete();
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
        M0_ARID = '0; M1_ARID = '0; M0_ARADDR = '0; M1_ARADDR = '0;
        M0_ARLEN = '0; M1_ARLEN = '0;
        M0_ARSIZE = 3'd3; M1_ARSIZE = 3'd3; M0_ARBURST = 2'b01; M1_ARBURST = 2'b01;
        M0_RREADY = 1'b1; M1_RREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({S_ARVALID, M0_ARREADY, M1_ARREADY, S_RREADY} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ar: got S_ARVALID/M0_ARREADY/M1_ARREADY/S_RREADY=%b, want 0000",
                     {S_ARVALID, M0_ARREADY, M1_ARREADY, S_RREADY});
        end
        checks++;
        if ({M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST, LEN_ERR} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_r: got RVALID0/1 RLAST0/1 LEN_ERR=%b, want 00000",
                     {M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST, LEN_ERR});
        end
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_single();
        int b0 = cnt_rv[0];
        int b1 = cnt_rv[1];
        int n = 0;
        ar_exp.push_back('{0, 4'h5, 32'h10, 4'd3, -1});
        ar_send(0, 4'h5, 32'h10, 4'd3);
        while (!M0_RVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (M0_RDATA !== 64'h0F0E0D0C0B0A0908 || M0_RID !== 4'h5 || M0_RVALID !== 1'b1) begin
            errors++;
            $display("FAIL single_first: got valid=%b data=%h id=%h, want 1 0f0e0d0c0b0a0908 5",
                     M0_RVALID, M0_RDATA, M0_RID);
        end
        wait_idle("single");
        checks++;
        if (cnt_rv[0] - b0 != 4 || cnt_rv[1] - b1 != 0) begin
            errors++;
            $display("FAIL single_count: got M0 %0d beats M1 %0d beats, want 4 and 0",
                     cnt_rv[0] - b0, cnt_rv[1] - b1);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ar_exp.push_back('{0, 4'h1, 32'h100, 4'd1, -1});
        ar_exp.push_back('{1, 4'h2, 32'h200, 4'd1, -1});
        ar_exp.push_back('{0, 4'h3, 32'h300, 4'd0, -1});
        ar_exp.push_back('{1, 4'h4, 32'h400, 4'd0, -1});
        fork
            ar_send(0, 4'h1, 32'h100, 4'd1);
            ar_send(1, 4'h2, 32'h200, 4'd1);
        join
        fork
            ar_send(0, 4'h3, 32'h300, 4'd0);
            ar_send(1, 4'h4, 32'h400, 4'd0);
        join
        wait_idle("simultaneous");
    endtask

    task automatic test_backpressure();
        int base = cnt_rv[1];
        int n = 0;
        ar_exp.push_back('{1, 4'h7, 32'h40, 4'd3, -1});
        ar_send(1, 4'h7, 32'h40, 4'd3);
        while (!(cnt_rv[1] == base + 1 && M1_RVALID) && n < 50) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        M1_RREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            checks++;
            if (S_RREADY !== 1'b0 || M1_RVALID !== 1'b1 || M1_RDATA !== 64'h4746454443424140) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got S_RREADY=%b RVALID=%b data=%h, want 0 1 4746454443424140",
                         c, S_RREADY, M1_RVALID, M1_RDATA);
            end
        end
        @(posedge ACLK);
        #1;
        M1_RREADY = 1'b1;
        wait_idle("backpressure");
        checks++;
        if (cnt_rv[1] - base != 4) begin
            errors++;
            $display("FAIL backpressure_count: got %0d beats, want 4", cnt_rv[1] - base);
        end
    endtask

    task automatic test_arlen0();
        ar_exp.push_back('{1, 4'h9, 32'h80, 4'd0, -1});
        ar_exp.push_back('{0, 4'h3, 32'h90, 4'd1, -1});
        fork
            ar_send(1, 4'h9, 32'h80, 4'd0);
            begin
                @(negedge ACLK);
                ar_send(0, 4'h3, 32'h90, 4'd1);
            end
            begin
                int n = 0;
                int gap = 0;
                while (!(M1_RVALID && M1_RLAST) && n < 50) begin
                    @(negedge ACLK);
                    n++;
                end
                do begin
                    @(negedge ACLK);
                    gap++;
                end while (!S_ARVALID && gap < 10);
                checks++;
                if (gap != 2) begin
                    errors++;
                    $display("FAIL arlen0_gap: got S_ARVALID %0d cycles after RLAST, want 2", gap);
                end
            end
        join
        wait_idle("arlen0");
    endtask

    task automatic test_len_err();
        checks++;
        if (LEN_ERR !== 1'b0) begin
            errors++;
            $display("FAIL len_err_pre: got %b, want 0", LEN_ERR);
        end
        early_idx = 1;
        ar_exp.push_back('{0, 4'h6, 32'h20, 4'd3, 1});
        ar_send(0, 4'h6, 32'h20, 4'd3);
        wait_idle("len_err");
        early_idx = -1;
        checks++;
        if (LEN_ERR !== LEN_CHK) begin
            errors++;
            $display("FAIL len_err_set: got %b, want %b", LEN_ERR, LEN_CHK);
        end
        ar_exp.push_back('{1, 4'h2, 32'h30, 4'd1, -1});
        ar_send(1, 4'h2, 32'h30, 4'd1);
        wait_idle("len_err_after");
        checks++;
        if (LEN_ERR !== LEN_CHK) begin
            errors++;
            $display("FAIL len_err_sticky: got %b, want %b", LEN_ERR, LEN_CHK);
        end
    endtask

    task automatic test_reset_mid();
        int base = cnt_rv[0];
        int n = 0;
        ar_exp.push_back('{0, 4'hC, 32'h60, 4'd3, -1});
        ar_send(0, 4'hC, 32'h60, 4'd3);
        while (!(cnt_rv[0] == base + 1 && M0_RVALID) && n < 50) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        #1;
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({M0_RVALID, M0_RLAST, S_RREADY, S_ARVALID, M0_ARREADY, M1_ARREADY, LEN_ERR} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid: got RVALID RLAST S_RREADY S_ARVALID ARREADY0/1 LEN_ERR=%b, want 0000000",
                     {M0_RVALID, M0_RLAST, S_RREADY, S_ARVALID, M0_ARREADY, M1_ARREADY, LEN_ERR});
        end
        @(negedge ACLK);
        beat_q.delete();
        ar_exp.delete();
        @(negedge ACLK);
        ARESETn = 1'b1;
        ar_exp.push_back('{0, 4'h1, 32'h70, 4'd0, -1});
        ar_exp.push_back('{1, 4'h2, 32'h78, 4'd0, -1});
        fork
            ar_send(0, 4'h1, 32'h70, 4'd0);
            ar_send(1, 4'h2, 32'h78, 4'd0);
        join
        wait_idle("reset_mid_after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_arlen0();
        test_len_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
